// File: rtl/axi_arb_pkg.sv
// Shared widths, FSM encoding and captured-command payload for the user-port arbiter.
package axi_arb_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STRB_W     = 4;
  localparam int unsigned BLEN_W     = 4;
  localparam int unsigned BEAT_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_W = 2'd2,
    WAIT_R = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [BLEN_W-1:0] blen;
  } arb_cmd_t;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
module axi_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic               any_c
);

  logic [IDX_W-1:0] cand;

  // Scan offsets 1..NUM_REQ from last_grant so the previous winner has lowest priority
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(last_grant) + off) % NUM_REQ);
      if (!any_c && req[cand]) begin
        any_c       = 1'b1;
        idx_c       = cand;
        gnt_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_user_arbiter.sv
// Round-robin sharing of the axi_master_fsm user command port among NUM_REQ requesters.
// One command in flight; completion tracked by snooping the AXI W/R handshakes.
// Optional watchdog: define AXI_ARB_TIMEOUT_EN to end a stalled command with REQ_ERR.
module axi_user_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      ACLK,
  input  logic                      ARESET_N,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ-1:0]        REQ_WRITE,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
  input  logic [NUM_REQ*STRB_W-1:0] REQ_STRB,
  input  logic [NUM_REQ*BLEN_W-1:0] REQ_BLEN,
  output logic [NUM_REQ-1:0]        REQ_READY,
  output logic [NUM_REQ-1:0]        REQ_RVALID,
  output logic [DATA_W-1:0]         REQ_RDATA,
  output logic [NUM_REQ-1:0]        REQ_DONE,
  output logic [NUM_REQ-1:0]        REQ_ERR,
  output logic                      U_WVALID,
  output logic                      U_RVALID,
  output logic [ADDR_W-1:0]         U_AWADDR,
  output logic [ADDR_W-1:0]         U_ARADDR,
  output logic [DATA_W-1:0]         U_WDATA,
  output logic [STRB_W-1:0]         U_STRB,
  output logic [BLEN_W-1:0]         U_BLEN,
  input  logic                      AXI_WVALID,
  input  logic                      AXI_WREADY,
  input  logic                      AXI_RVALID,
  input  logic                      AXI_RREADY,
  input  logic [DATA_W-1:0]         AXI_RDATA
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [IDX_W-1:0]        gnt_q, gnt_d;
  arb_cmd_t                cmd_q, cmd_d;
  logic [BEAT_CNT_W-1:0]   beats_q, beats_d;
  logic                    u_wvalid_q, u_wvalid_d;
  logic                    u_rvalid_q, u_rvalid_d;
  logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      done_q, done_d;

  logic [ADDR_W-1:0]       req_addr  [NUM_REQ];
  logic [DATA_W-1:0]       req_wdata [NUM_REQ];
  logic [STRB_W-1:0]       req_strb  [NUM_REQ];
  logic [BLEN_W-1:0]       req_blen  [NUM_REQ];

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [NUM_REQ-1:0]      gnt_oh;
  logic                    in_flight;
  logic                    w_beat;
  logic                    r_beat;
  logic [BEAT_CNT_W-1:0]   beat_next;
  logic                    beat_last;

  // Split flat per-requester buses into indexable arrays
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_addr[i]  = REQ_ADDR[i*ADDR_W +: ADDR_W];
    assign req_wdata[i] = REQ_WDATA[i*DATA_W +: DATA_W];
    assign req_strb[i]  = REQ_STRB[i*STRB_W +: STRB_W];
    assign req_blen[i]  = REQ_BLEN[i*BLEN_W +: BLEN_W];
  end

  axi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (REQ_VALID),
    .last_grant (last_grant_q),
    .gnt_c      (pick_gnt),
    .idx_c      (pick_idx),
    .any_c      (pick_any)
  );

  // Beats only count while a command of the matching direction is in ISSUE or WAIT
  assign gnt_oh    = NUM_REQ'(1) << gnt_q;
  assign in_flight = (state_q != IDLE);
  assign w_beat    = in_flight &&  cmd_q.write && AXI_WVALID && AXI_WREADY;
  assign r_beat    = in_flight && !cmd_q.write && AXI_RVALID && AXI_RREADY;
  assign beat_next = beats_q + BEAT_CNT_W'(1);
  assign beat_last = (beat_next == (BEAT_CNT_W'(cmd_q.blen) + BEAT_CNT_W'(1)));

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               in_wait;
  assign in_wait = (state_q == WAIT_W) || (state_q == WAIT_R);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cmd_d        = cmd_q;
    beats_d      = beats_q;
    u_wvalid_d   = 1'b0;
    u_rvalid_d   = 1'b0;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    done_d       = '0;
`ifdef AXI_ARB_TIMEOUT_EN
    err_d        = '0;
    wd_d         = '0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d       = ISSUE;
          last_grant_d  = pick_idx;
          gnt_d         = pick_idx;
          cmd_d.write   = REQ_WRITE[pick_idx];
          cmd_d.addr    = req_addr[pick_idx];
          cmd_d.wdata   = req_wdata[pick_idx];
          cmd_d.strb    = req_strb[pick_idx];
          cmd_d.blen    = req_blen[pick_idx];
          beats_d       = '0;
          u_wvalid_d    = REQ_WRITE[pick_idx];
          u_rvalid_d    = !REQ_WRITE[pick_idx];
        end
      end
      ISSUE:   state_d = cmd_q.write ? WAIT_W : WAIT_R;
      WAIT_W:  state_d = WAIT_W;
      WAIT_R:  state_d = WAIT_R;
      default: state_d = IDLE;
    endcase

    if (w_beat) begin
      done_d  = gnt_oh;
      state_d = IDLE;
    end

    if (r_beat) begin
      rvalid_d = gnt_oh;
      rdata_d  = AXI_RDATA;
      beats_d  = beat_next;
      if (beat_last) begin
        done_d  = gnt_oh;
        beats_d = '0;
        state_d = IDLE;
      end
    end

`ifdef AXI_ARB_TIMEOUT_EN
    if (in_wait && !w_beat && !r_beat) begin
      wd_d = wd_q + WD_W'(1);
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        done_d  = gnt_oh;
        err_d   = gnt_oh;
        beats_d = '0;
        state_d = IDLE;
      end
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      cmd_q        <= '0;
      beats_q      <= '0;
      u_wvalid_q   <= 1'b0;
      u_rvalid_q   <= 1'b0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cmd_q        <= cmd_d;
      beats_q      <= beats_d;
      u_wvalid_q   <= u_wvalid_d;
      u_rvalid_q   <= u_rvalid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  // Watchdog counter and error pulse
  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      wd_q  <= '0;
      err_q <= '0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign REQ_ERR = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign REQ_ERR        = '0;
`endif

  // Grant is offered only while idle so nothing is accepted mid-command
  assign REQ_READY  = (state_q == IDLE) ? pick_gnt : '0;
  assign REQ_RVALID = rvalid_q;
  assign REQ_RDATA  = rdata_q;
  assign REQ_DONE   = done_q;
  assign U_WVALID   = u_wvalid_q;
  assign U_RVALID   = u_rvalid_q;
  assign U_AWADDR   = cmd_q.addr;
  assign U_ARADDR   = cmd_q.addr;
  assign U_WDATA    = cmd_q.wdata;
  assign U_STRB     = cmd_q.strb;
  assign U_BLEN     = cmd_q.blen;

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Directed self-checking bench for axi_user_arbiter with two requesters.
module tb_axi_user_arbiter;

  logic        ACLK;
  logic        ARESET_N;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_WRITE;
  logic [63:0] REQ_ADDR;
  logic [63:0] REQ_WDATA;
  logic [7:0]  REQ_STRB;
  logic [7:0]  REQ_BLEN;
  logic [1:0]  REQ_READY;
  logic [1:0]  REQ_RVALID;
  logic [31:0] REQ_RDATA;
  logic [1:0]  REQ_DONE;
  logic [1:0]  REQ_ERR;
  logic        U_WVALID;
  logic        U_RVALID;
  logic [31:0] U_AWADDR;
  logic [31:0] U_ARADDR;
  logic [31:0] U_WDATA;
  logic [3:0]  U_STRB;
  logic [3:0]  U_BLEN;
  logic        AXI_WVALID;
  logic        AXI_WREADY;
  logic        AXI_RVALID;
  logic        AXI_RREADY;
  logic [31:0] AXI_RDATA;

  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic [3:0]  strb_a  [2];
  logic [3:0]  blen_a  [2];

  int n_checks = 0;
  int n_fail   = 0;

  assign REQ_ADDR  = {addr_a[1],  addr_a[0]};
  assign REQ_WDATA = {wdata_a[1], wdata_a[0]};
  assign REQ_STRB  = {strb_a[1],  strb_a[0]};
  assign REQ_BLEN  = {blen_a[1],  blen_a[0]};

  axi_user_arbiter #(
    .NUM_REQ (2),
    .TIMEOUT (64)
  ) dut (
    .ACLK       (ACLK),
    .ARESET_N   (ARESET_N),
    .REQ_VALID  (REQ_VALID),
    .REQ_WRITE  (REQ_WRITE),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_WDATA  (REQ_WDATA),
    .REQ_STRB   (REQ_STRB),
    .REQ_BLEN   (REQ_BLEN),
    .REQ_READY  (REQ_READY),
    .REQ_RVALID (REQ_RVALID),
    .REQ_RDATA  (REQ_RDATA),
    .REQ_DONE   (REQ_DONE),
    .REQ_ERR    (REQ_ERR),
    .U_WVALID   (U_WVALID),
    .U_RVALID   (U_RVALID),
    .U_AWADDR   (U_AWADDR),
    .U_ARADDR   (U_ARADDR),
    .U_WDATA    (U_WDATA),
    .U_STRB     (U_STRB),
    .U_BLEN     (U_BLEN),
    .AXI_WVALID (AXI_WVALID),
    .AXI_WREADY (AXI_WREADY),
    .AXI_RVALID (AXI_RVALID),
    .AXI_RREADY (AXI_RREADY),
    .AXI_RDATA  (AXI_RDATA)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Hard stop in case the sequence ever stalls
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [1:0] oh(input logic r);
    return 2'(1) << r;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One write by requester r; caller has set REQ_VALID/REQ_WRITE and the fields
  task automatic run_write(input logic r);
    #1;
    check("wr_ready_idle", 32'(REQ_READY), 32'(oh(r)));
    tick();
    check("wr_issue_wvalid", 32'(U_WVALID), 32'd1);
    check("wr_issue_rvalid", 32'(U_RVALID), 32'd0);
    check("wr_issue_awaddr", U_AWADDR, addr_a[r]);
    check("wr_issue_wdata", U_WDATA, wdata_a[r]);
    check("wr_issue_strb", 32'(U_STRB), 32'(strb_a[r]));
    check("wr_issue_noready", 32'(REQ_READY), 32'd0);
    check("wr_issue_nodone", 32'(REQ_DONE), 32'd0);
    tick();
    check("wr_wait_wvalid", 32'(U_WVALID), 32'd0);
    check("wr_wait_noready", 32'(REQ_READY), 32'd0);
    check("wr_wait_wdata_held", U_WDATA, wdata_a[r]);
    AXI_WVALID = 1'b1;
    AXI_WREADY = 1'b1;
    tick();
    AXI_WVALID = 1'b0;
    AXI_WREADY = 1'b0;
    check("wr_done", 32'(REQ_DONE), 32'(oh(r)));
    check("wr_err", 32'(REQ_ERR), 32'd0);
  endtask

  // One read burst by requester r with blen+1 beats, then one stray beat in IDLE
  task automatic run_read(input logic r, input logic [3:0] blen, input logic [31:0] base);
    REQ_VALID = oh(r);
    REQ_WRITE = 2'b00;
    addr_a[r] = base;
    blen_a[r] = blen;
    #1;
    check("rd_ready_idle", 32'(REQ_READY), 32'(oh(r)));
    tick();
    REQ_VALID = 2'b00;
    check("rd_issue_rvalid", 32'(U_RVALID), 32'd1);
    check("rd_issue_wvalid", 32'(U_WVALID), 32'd0);
    check("rd_issue_blen", 32'(U_BLEN), 32'(blen));
    check("rd_issue_araddr", U_ARADDR, base);
    tick();
    check("rd_wait_rvalid", 32'(U_RVALID), 32'd0);
    check("rd_wait_noreqrv", 32'(REQ_RVALID), 32'd0);
    for (int k = 0; k <= int'(blen); k++) begin
      AXI_RVALID = 1'b1;
      AXI_RREADY = 1'b1;
      AXI_RDATA  = base ^ 32'(k);
      tick();
      check("rd_beat_valid", 32'(REQ_RVALID), 32'(oh(r)));
      check("rd_beat_data", REQ_RDATA, base ^ 32'(k));
      check("rd_beat_done", 32'(REQ_DONE), (k == int'(blen)) ? 32'(oh(r)) : 32'd0);
    end
    AXI_RDATA = 32'hDEAD_BEEF;
    tick();
    AXI_RVALID = 1'b0;
    AXI_RREADY = 1'b0;
    check("rd_stray_novalid", 32'(REQ_RVALID), 32'd0);
    check("rd_stray_nodone", 32'(REQ_DONE), 32'd0);
    check("rd_stray_data_held", REQ_RDATA, base ^ 32'(blen));
  endtask

  initial begin
    ARESET_N   = 1'b0;
    REQ_VALID  = 2'b00;
    REQ_WRITE  = 2'b00;
    addr_a[0]  = '0;  addr_a[1]  = '0;
    wdata_a[0] = '0;  wdata_a[1] = '0;
    strb_a[0]  = '0;  strb_a[1]  = '0;
    blen_a[0]  = '0;  blen_a[1]  = '0;
    AXI_WVALID = 1'b0;
    AXI_WREADY = 1'b0;
    AXI_RVALID = 1'b0;
    AXI_RREADY = 1'b0;
    AXI_RDATA  = '0;

    // Reset values
    tick();
    tick();
    check("rst_ready", 32'(REQ_READY), 32'd0);
    check("rst_rvalid", 32'(REQ_RVALID), 32'd0);
    check("rst_rdata", REQ_RDATA, 32'd0);
    check("rst_done", 32'(REQ_DONE), 32'd0);
    check("rst_err", 32'(REQ_ERR), 32'd0);
    check("rst_u_valids", {30'd0, U_WVALID, U_RVALID}, 32'd0);
    check("rst_u_addr", U_AWADDR | U_ARADDR, 32'd0);
    check("rst_u_fields", {20'd0, U_STRB, U_BLEN, 4'd0}, 32'd0);
    ARESET_N = 1'b1;
    tick();

    // Single write from requester 0
    addr_a[0]  = 32'h0000_0000;
    wdata_a[0] = 32'h1234_5678;
    strb_a[0]  = 4'b0001;
    REQ_WRITE  = 2'b01;
    REQ_VALID  = 2'b01;
    run_write(1'b0);
    REQ_VALID  = 2'b00;
    tick();
    check("wr_done_pulse_end", 32'(REQ_DONE), 32'd0);

    // Four-beat read from requester 1
    run_read(1'b1, 4'd3, 32'h1000_0040);

    // Contention: both writing, grants alternate starting at 0
    addr_a[0]  = 32'h0000_0100;  wdata_a[0] = 32'h0000_AAAA;  strb_a[0] = 4'b0011;
    addr_a[1]  = 32'h0000_0200;  wdata_a[1] = 32'h5555_0000;  strb_a[1] = 4'b1100;
    REQ_WRITE  = 2'b11;
    REQ_VALID  = 2'b11;
    run_write(1'b0);
    run_write(1'b1);
    run_write(1'b0);
    run_write(1'b1);
    REQ_VALID  = 2'b00;
    tick();

    // Burst length edges
    run_read(1'b0, 4'd0,  32'hA000_0000);
    run_read(1'b1, 4'd15, 32'hB000_0100);

    // Reset in the middle of a four-beat read
    addr_a[0] = 32'h0000_2000;
    blen_a[0] = 4'd3;
    REQ_WRITE = 2'b00;
    REQ_VALID = 2'b01;
    tick();
    REQ_VALID = 2'b00;
    tick();
    AXI_RVALID = 1'b1;
    AXI_RREADY = 1'b1;
    AXI_RDATA  = 32'h0000_00C1;
    tick();
    AXI_RDATA  = 32'h0000_00C2;
    tick();
    AXI_RVALID = 1'b0;
    AXI_RREADY = 1'b0;
    check("mid_beat2_valid", 32'(REQ_RVALID), 32'b01);
    check("mid_beat2_data", REQ_RDATA, 32'h0000_00C2);
    ARESET_N = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(REQ_RVALID), 32'd0);
    check("mid_rst_rdata", REQ_RDATA, 32'd0);
    check("mid_rst_araddr", U_ARADDR, 32'd0);
    check("mid_rst_blen", 32'(U_BLEN), 32'd0);
    check("mid_rst_done", 32'(REQ_DONE), 32'd0);
    tick();
    ARESET_N = 1'b1;
    tick();

    // After reset requester 0 wins again even though it was granted last
    addr_a[0]  = 32'h0000_3000;  wdata_a[0] = 32'hCAFE_0001;  strb_a[0] = 4'b1111;
    REQ_WRITE  = 2'b11;
    REQ_VALID  = 2'b11;
    run_write(1'b0);
    REQ_VALID  = 2'b00;
    tick();

`ifdef AXI_ARB_TIMEOUT_EN
    // Read that never receives a beat ends with DONE and ERR after the watchdog
    addr_a[0] = 32'h0000_4000;
    blen_a[0] = 4'd0;
    REQ_WRITE = 2'b00;
    REQ_VALID = 2'b01;
    tick();
    REQ_VALID = 2'b00;
    tick();
    repeat (63) tick();
    check("to_before", 32'(REQ_DONE), 32'd0);
    tick();
    check("to_done", 32'(REQ_DONE), 32'b01);
    check("to_err", 32'(REQ_ERR), 32'b01);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
